// File: rtl/reg_bus_reader.sv
// Register bank read-out: drives one register onto the result bus and
// optionally stores it to pixel memory through a req/ack handshake.
module reg_bus_reader #(
   parameter int N_REGS  = 8,
   parameter int AW      = 12,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [2:0]        rd_sel,
   input  logic              st_en,
   input  logic [8*N_REGS-1:0] regs_in,
   input  logic              addr_load,
   input  logic [AW-1:0]     addr_in,
   output logic [7:0]        bus_out,
   output logic              bus_valid,
   output logic              mem_req,
   output logic [AW-1:0]     mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LATCH,
      S_REQ,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    data_q, data_d;
   logic [7:0]    bus_q, bus_d;
   logic          st_q, st_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [7:0]    tcnt_q, tcnt_d;
   logic          err_q, err_d;
   logic [7:0]    sel_val;
   logic          sel_ok;

   assign sel_ok = ({1'b0, rd_sel} < 4'(N_REGS));

   always_comb begin
      sel_val = 8'h00;
      for (int i = 0; i < N_REGS; i++) begin
         if (rd_sel == 3'(i)) sel_val = regs_in[8*i +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      bus_d   = bus_q;
      st_d    = st_q;
      ptr_d   = ptr_q;
      tcnt_d  = tcnt_q;
      err_d   = 1'b0;

      if (addr_load && state_q != S_REQ) ptr_d = addr_in;

      unique case (state_q)
         S_IDLE: begin
            if (rd_en) begin
               if (sel_ok) begin
                  data_d  = sel_val;
                  bus_d   = sel_val;
                  st_d    = st_en;
                  state_d = S_LATCH;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LATCH: begin
            tcnt_d  = 8'd0;
            state_d = st_q ? S_REQ : S_DONE;
         end
         S_REQ: begin
            if (mem_ack) begin
               ptr_d   = ptr_q + AW'(1);
               state_d = S_DONE;
            end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tcnt_d = tcnt_q + 8'd1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= 8'h00;
         bus_q   <= 8'h00;
         st_q    <= 1'b0;
         ptr_q   <= '0;
         tcnt_q  <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         bus_q   <= bus_d;
         st_q    <= st_d;
         ptr_q   <= ptr_d;
         tcnt_q  <= tcnt_d;
         err_q   <= err_d;
      end
   end

   // Strobes decode straight from state so a reset drops them at once.
   assign bus_out   = bus_q;
   assign bus_valid = (state_q == S_LATCH);
   assign mem_req   = (state_q == S_REQ);
   assign mem_addr  = ptr_q;
   assign mem_wdata = data_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;

endmodule
